// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one combinational 16x16 signed multiplier among N_REQ requesters.
// Two registered stages: operand register feeding the multiplier, and a backpressured result slot.

module mult_16_16_top (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] pp [9];
  logic [31:0] a_ext;
  logic [16:0] b_ext;

  logic [31:0] s0, c0, s1, c1, s2, c2;
  logic [31:0] t0, d0, t1, d1;
  logic [31:0] u0, e0;
  logic [31:0] v0, f0;

  function automatic logic [31:0] csa_sum(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [31:0] csa_carry(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // Radix-4 Booth rows use one's complement for negative digits; row 8 collects the +1 corrections.
  always_comb begin
    logic [2:0]  trip;
    logic        one, two, neg;
    logic [31:0] mag;
    a_ext = {{16{a[15]}}, a};
    b_ext = {b, 1'b0};
    pp[8] = '0;
    for (int i = 0; i < 8; i++) begin
      trip = b_ext[2*i+2 -: 3];
      one  = trip[1] ^ trip[0];
      two  = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
      neg  = trip[2];
      if (one) begin
        mag = a_ext;
      end else if (two) begin
        mag = a_ext << 1;
      end else begin
        mag = '0;
      end
      pp[i] = (neg ? ~mag : mag) << (2 * i);
      pp[8][2*i] = neg;
    end
  end

  // Wallace reduction 9 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add.
  always_comb begin
    s0 = csa_sum(pp[0], pp[1], pp[2]);
    c0 = csa_carry(pp[0], pp[1], pp[2]);
    s1 = csa_sum(pp[3], pp[4], pp[5]);
    c1 = csa_carry(pp[3], pp[4], pp[5]);
    s2 = csa_sum(pp[6], pp[7], pp[8]);
    c2 = csa_carry(pp[6], pp[7], pp[8]);
    t0 = csa_sum(s0, c0, s1);
    d0 = csa_carry(s0, c0, s1);
    t1 = csa_sum(c1, s2, c2);
    d1 = csa_carry(c1, s2, c2);
    u0 = csa_sum(t0, d0, t1);
    e0 = csa_carry(t0, d0, t1);
    v0 = csa_sum(u0, e0, d1);
    f0 = csa_carry(u0, e0, d1);
    p  = v0 + f0;
  end

endmodule

module mult_share_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_prod,
  output logic [15:0]           op_cnt
);

  logic [15:0]     op_a, op_b;
  logic [ID_W-1:0] op_id;
  logic            op_vld;
  logic [ID_W-1:0] rr_ptr;

  logic [ID_W-1:0] winner;
  logic            found;
  logic            s0_free, s1_free;
  logic            accept, s0_move;
  logic [15:0]     sel_a, sel_b;
  logic [31:0]     mult_p;

  assign s1_free = !rsp_valid || rsp_ready;
  assign s0_free = !op_vld || s1_free;
  assign s0_move = op_vld && s1_free;

  // Circular search for the first valid request at or after rr_ptr.
  always_comb begin
    logic [ID_W:0] sum;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      if (!found && req_valid[sum[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[ID_W-1:0];
      end
    end
  end

  assign accept = found && s0_free && !sys_rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    sel_a = req_a[16*winner +: 16];
    sel_b = req_b[16*winner +: 16];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      op_vld <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
      rr_ptr <= '0;
      op_cnt <= '0;
    end else if (accept) begin
      op_vld <= 1'b1;
      op_a   <= sel_a;
      op_b   <= sel_b;
      op_id  <= winner;
      rr_ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
      op_cnt <= op_cnt + 16'd1;
    end else if (s0_move) begin
      op_vld <= 1'b0;
    end
  end

  mult_16_16_top u_mult (
    .a (op_a),
    .b (op_b),
    .p (mult_p)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
    end else if (s0_move) begin
      rsp_valid <= 1'b1;
      rsp_prod  <= mult_p;
      rsp_id    <= op_id;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Randomized and directed bench for mult_share_sched against a queue-based reference model.

module tb_mult_share_sched;

  localparam int N = 4;

  logic            sys_clk = 1'b0;
  logic            sys_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_prod;
  logic [15:0]     op_cnt;

  mult_share_sched #(.N_REQ(N), .ID_W(2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .op_cnt    (op_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: ordered list of in-flight operations, each tagged with the stage it occupies.
  typedef struct {
    int          id;
    logic [31:0] prod;
    int          stage;
  } op_t;

  op_t         q[$];
  int          m_rr = 0;
  int          m_cnt = 0;
  logic [31:0] m_prod = '0;
  int          m_id = 0;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] sa, sb;
    logic signed [31:0] r;
    sa = a;
    sb = b;
    r  = sa * sb;
    return r;
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic rst,
                       output logic [N-1:0] obs);
    logic        s1_occ, s0_occ, s1_free, s0_free, found, acc;
    int          w, idx;
    logic [N-1:0] exp_ready;
    op_t         e;
    sys_rst   = rst;
    req_valid = v;
    rsp_ready = rdy;
    @(negedge sys_clk);
    s1_occ = (q.size() > 0) && (q[0].stage == 1);
    s0_occ = (q.size() > 0) && (q[q.size()-1].stage == 0);
    check_eq("rsp_valid", {31'b0, rsp_valid}, {31'b0, s1_occ});
    check_eq("rsp_prod", rsp_prod, m_prod);
    check_eq("rsp_id", {30'b0, rsp_id}, 32'(m_id));
    check_eq("op_cnt", {16'b0, op_cnt}, 32'(m_cnt));
    s1_free = !s1_occ || rdy;
    s0_free = !s0_occ || s1_free;
    found = 1'b0;
    w = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && v[(m_rr + k) % N]) begin
        found = 1'b1;
        w = (m_rr + k) % N;
      end
    end
    acc = found && s0_free && !rst;
    exp_ready = acc ? N'(1 << w) : '0;
    check_eq("req_ready", {28'b0, req_ready}, {28'b0, exp_ready});
    obs = req_ready;
    if (rst) begin
      q.delete();
      m_rr = 0;
      m_cnt = 0;
      m_prod = '0;
      m_id = 0;
    end else begin
      if (s1_occ && rdy) void'(q.pop_front());
      if (s0_occ && s1_free) begin
        idx = q.size() - 1;
        e = q[idx];
        e.stage = 1;
        q[idx] = e;
        m_prod = e.prod;
        m_id = e.id;
      end
      if (acc) begin
        e.id = w;
        e.prod = ref_mul(req_a[16*w +: 16], req_b[16*w +: 16]);
        e.stage = 0;
        q.push_back(e);
        m_rr = (w + 1) % N;
        m_cnt = (m_cnt + 1) & 16'hFFFF;
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_lane(input int id, input logic [15:0] a, input logic [15:0] b);
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
  endtask

  task automatic one_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string tag);
    logic [N-1:0] o;
    set_lane(id, a, b);
    cycle(N'(1 << id), 1'b1, 1'b0, o);
    cycle('0, 1'b1, 1'b0, o);
    check_eq({tag, "_vld"}, {31'b0, rsp_valid}, 32'd1);
    check_eq({tag, "_prod"}, rsp_prod, exp);
    check_eq({tag, "_id"}, {30'b0, rsp_id}, 32'(id));
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [N-1:0] o;
    sys_rst   = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_prod", rsp_prod, 32'd0);
    check_eq("rst_rsp_id", {30'b0, rsp_id}, 32'd0);
    check_eq("rst_op_cnt", {16'b0, op_cnt}, 32'd0);
    check_eq("rst_req_ready", {28'b0, req_ready}, 32'd0);

    // Basic product with k+2 latency.
    one_op(0, 16'hFFFE, 16'h0003, 32'hFFFFFFFA, "basic");
    check_eq("basic_cnt", {16'b0, op_cnt}, 32'd1);

    one_op(2, 16'h7FFF, 16'h8000, 32'hC0008000, "corner_a");
    one_op(2, 16'h8000, 16'h8000, 32'h40000000, "corner_b");
    one_op(2, 16'h0000, 16'h1234, 32'h00000000, "corner_c");
    cycle('0, 1'b1, 1'b0, o);

    // Reset one cycle after a handshake drops the operation.
    set_lane(0, 16'h0101, 16'h0202);
    cycle(4'b0001, 1'b1, 1'b0, o);
    cycle('0, 1'b1, 1'b1, o);
    repeat (3) cycle('0, 1'b1, 1'b0, o);
    check_eq("rstmid_cnt", {16'b0, op_cnt}, 32'd0);
    check_eq("rstmid_vld", {31'b0, rsp_valid}, 32'd0);
    cycle(4'b1111, 1'b1, 1'b0, o);
    check_eq("rstmid_grant", {28'b0, o}, 32'd1);
    repeat (2) cycle('0, 1'b1, 1'b0, o);

    // Backpressure: requesters 1 and 3 pending with the slot stalled for 4 cycles.
    set_lane(1, 16'd3, 16'd5);
    set_lane(3, 16'hFFF9, 16'd9);
    cycle(4'b1010, 1'b0, 1'b0, o);
    check_eq("bp_grant1", {28'b0, o}, 32'b0010);
    cycle(4'b1000, 1'b0, 1'b0, o);
    check_eq("bp_grant3", {28'b0, o}, 32'b1000);
    check_eq("bp_first_id", {30'b0, rsp_id}, 32'd1);
    check_eq("bp_first_prod", rsp_prod, 32'd15);
    cycle(4'b1010, 1'b0, 1'b0, o);
    check_eq("bp_stall_ready_a", {28'b0, o}, 32'd0);
    cycle(4'b1010, 1'b0, 1'b0, o);
    check_eq("bp_stall_ready_b", {28'b0, o}, 32'd0);
    check_eq("bp_hold_id", {30'b0, rsp_id}, 32'd1);
    check_eq("bp_hold_prod", rsp_prod, 32'd15);
    cycle('0, 1'b1, 1'b0, o);
    check_eq("bp_second_id", {30'b0, rsp_id}, 32'd3);
    check_eq("bp_second_prod", rsp_prod, 32'hFFFFFFC1);
    cycle('0, 1'b1, 1'b0, o);
    check_eq("bp_done", {31'b0, rsp_valid}, 32'd0);

    // Withdrawn request: 1 loses to 0 once, then wins alone.
    cycle(4'b0011, 1'b1, 1'b0, o);
    check_eq("wd_grant0", {28'b0, o}, 32'b0001);
    cycle(4'b0010, 1'b1, 1'b0, o);
    check_eq("wd_grant1", {28'b0, o}, 32'b0010);
    repeat (2) cycle('0, 1'b1, 1'b0, o);

    // Fairness from a fresh pointer.
    cycle('0, 1'b1, 1'b1, o);
    for (int i = 0; i < N; i++) set_lane(i, 16'(100 + i), 16'(i - 2));
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b1, 1'b0, o);
      check_eq("fair_grant", {28'b0, o}, 32'(1 << (i % 4)));
    end
    repeat (2) cycle('0, 1'b1, 1'b0, o);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) set_lane(i, pick_operand(), pick_operand());
      cycle(N'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0, o);
    end
    repeat (3) cycle('0, 1'b1, 1'b0, o);

    // op_cnt wrap after 65536 accepts.
    cycle('0, 1'b1, 1'b1, o);
    set_lane(0, 16'h0002, 16'h0003);
    for (int i = 0; i < 65535; i++) cycle(4'b0001, 1'b1, 1'b0, o);
    check_eq("wrap_max", {16'b0, op_cnt}, 32'h0000FFFF);
    cycle(4'b0001, 1'b1, 1'b0, o);
    check_eq("wrap_zero", {16'b0, op_cnt}, 32'd0);
    repeat (2) cycle('0, 1'b1, 1'b0, o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Round-robin scheduler that shares one combinational 16×16 signed Booth-2/Wallace multiplier (`mult_16_16_top`) among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and registers the granted pair into the multiplier inputs. It registers the 32-bit product with the requester ID into a single output slot that honours backpressure. It sits between the requesting datapath blocks and the multiplier instance, which it contains.

## Interface
- `N_REQ`, 4: number of requesters, 2..8
- `ID_W`, 2: width of requester ID, `ceil(log2(N_REQ))`, minimum 1
- `sys_clk`  in  1  single clock, all logic on the rising edge
- `sys_rst`  in  1  reset; synchronous and active-high
- `req_valid`  in  N_REQ  bit i: requester i presents an operand pair
- `req_ready`  out  N_REQ  bit i: requester i's pair is taken this cycle; at most one bit is high
- `req_a`  in  16·N_REQ  multiplicand of requester i at `[16i+15:16i]`, two's complement
- `req_b`  in  16·N_REQ  multiplier of requester i at `[16i+15:16i]`, two's complement
- `rsp_valid`  out  1  product slot holds a result
- `rsp_ready`  in  1  consumer takes the result
- `rsp_id`  out  ID_W  index of the requester that issued the result
- `rsp_prod`  out  32  signed product A·B
- `op_cnt`  out  16  count of accepted operations, wraps at 0xFFFF→0

## Operation
- Pipeline stages:
  - S0, operand register: `op_a`, `op_b`, `op_id`, `op_vld`. `op_a`/`op_b` drive the multiplier inputs directly.
  - S1, output slot: `rsp_prod`, `rsp_id`, `rsp_valid`. Captures the multiplier output.
- Advance conditions:
  - `s1_free = !rsp_valid || rsp_ready`
  - `s0_free = !op_vld || s1_free`
- Arbitration, combinational each cycle:
  - Search `req_valid` starting at pointer `rr_ptr`, then `rr_ptr+1`, …, modulo N_REQ.
  - The first set bit is the winner.
  - `req_ready[winner] = s0_free`; all other ready bits are 0.
  - When no request is valid, all ready bits are 0.
- Accept, when the winner's valid and ready are both high:
  - S0 loads the winner's operands and ID, and sets `op_vld = 1`.
  - `rr_ptr ← (winner+1) mod N_REQ`.
  - `op_cnt` increments.
- `rr_ptr` is unchanged on cycles with no accept.
- S0 move, when `op_vld && s1_free`:
  - S1 loads the multiplier output and `op_id`, and sets `rsp_valid = 1`.
  - If no new accept happens in the same cycle, `op_vld` clears.
- S1 drain: on `rsp_valid && rsp_ready` with no S0 move, `rsp_valid` clears.
- Simultaneous S1 drain, S0 move and new accept is legal and gives full throughput.
- Hold rules:
  - While `rsp_valid && !rsp_ready`, `rsp_prod` and `rsp_id` hold stable.
  - While that stall lasts and `op_vld` is high, all `req_ready` are 0.
- `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- A requester that deasserts `req_valid` before its handshake is simply skipped, with no side effect.
- Arithmetic:
  - Full 32-bit two's-complement product.
  - No saturation. `0x8000·0x8000 = 0x40000000`.
- Reset while busy:
  - Drops any in-flight S0/S1 content; no result is emitted.
  - Outputs reach their reset values on the cycle after the reset edge.

## Timing
- Reset values:
  - `req_ready` 0, `rsp_valid` 0, `rsp_prod` 0, `rsp_id` 0, `op_cnt` 0
  - internal: `op_vld` 0, `rr_ptr` 0
  - `req_ready` may go high combinationally in the first cycle after reset once a valid arrives.
- Latency: handshake in cycle k, `rsp_valid` high in cycle k+2 with the product.
- Throughput: one product per cycle while `rsp_ready` stays high.
- Multiplier path: register (`op_a`/`op_b`) → `mult_16_16_top` → register (`rsp_prod`). It is the critical path and has one full cycle.
- Stall behaviour, with `rsp_ready` low:
  - At most 2 operations are in flight.
  - Acceptance resumes in the same cycle that `rsp_ready` rises.
- Starvation bound: a continuously valid requester is granted within N_REQ accepts.

## Test plan
- Basic product: requester 0 sends A=0xFFFE, B=0x0003 with `rsp_ready=1` → `rsp_valid` in cycle k+2, `rsp_prod=0xFFFFFFFA`, `rsp_id=0`, `op_cnt=1`.
- Corner operands on requester 2:
  - 0x7FFF·0x8000 → `rsp_prod=0xC0008000`, `rsp_id=2`
  - 0x8000·0x8000 → `rsp_prod=0x40000000`
  - 0x0000·0x1234 → `rsp_prod=0`
- Fairness: all 4 requesters valid continuously for 8 accepts →
  - grant order 0,1,2,3,0,1,2,3
  - one result per cycle from cycle 2 onward
  - each result matches its own operands
- Backpressure:
  - Drive `rsp_ready=0` for 4 cycles while requests 1 and 3 are pending.
  - Required: `rsp_prod` and `rsp_id` stable, exactly 2 operations in flight, all `req_ready=0` during the stall.
  - After `rsp_ready=1`, both results arrive in order 1, 3 with no loss or duplicate.
- Sparse/withdrawn request: requester 1 raises valid for one cycle while requester 0 wins → requester 1 is not accepted and `op_cnt` is unchanged for it. Then `rr_ptr=1` and requester 1 wins on its next valid.
- Reset mid-operation:
  - Assert `sys_rst` one cycle after a handshake.
  - Required: no `rsp_valid` afterwards, `op_cnt=0`, grant restarts at requester 0.
- `op_cnt` wrap: 65536 accepts → `op_cnt` returns to 0.
